// File: rtl/encoder_pkg.sv
// Shared types and constants for the code-disc encoder tracker.
// Holds the tracker state encoding, edge-mode codes and the Q2 ratio scale.
package encoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_e;

  localparam logic [1:0] EDGE_RISE     = 2'd0;
  localparam logic [1:0] EDGE_FALL     = 2'd1;
  localparam logic [1:0] EDGE_BOTH     = 2'd2;
  localparam logic [1:0] EDGE_RISE_ALT = 2'd3;

  // The gap ratio is expressed in quarters, so the current period is scaled by 4.
  localparam int Q2_SCALE = 4;

  function automatic bit addr_w_ok(input int tooth_num, input int addr_w);
    return (tooth_num >= 1) && ((64'd1 << addr_w) >= 64'(tooth_num));
  endfunction

endpackage

// File: rtl/encoder_input_filter.sv
// Front end for the opto code-disc input: 2-FF synchroniser, stability filter
// with calibration bypass, and edge-mode selection producing a one-cycle pulse.
module encoder_input_filter
  import encoder_pkg::*;
#(
  parameter int FILTER_CYC = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sig,
  input  logic [1:0] i_edge_mode,
  input  logic       i_cal_mode,
  output logic       o_edge
);

  localparam int CNT_W = $clog2(FILTER_CYC + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q, filt_d;
  logic             lvl_prev_q, lvl_prev_d;
  logic             edge_q, edge_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic             lvl, rise, fall;

  always_comb begin
    sync1_d    = i_sig;
    sync2_d    = sync1_q;
    filt_d     = filt_q;
    stab_cnt_d = '0;
    // In calibration the filter just follows the synchroniser so leaving
    // bypass does not create a phantom edge.
    if (i_cal_mode) begin
      filt_d = sync2_q;
    end else if (sync2_q != filt_q) begin
      if (stab_cnt_q == CNT_W'(FILTER_CYC - 1)) begin
        filt_d = sync2_q;
      end else begin
        stab_cnt_d = stab_cnt_q + CNT_W'(1);
      end
    end

    lvl        = i_cal_mode ? sync2_q : filt_q;
    rise       = lvl & ~lvl_prev_q;
    fall       = ~lvl & lvl_prev_q;
    lvl_prev_d = lvl;

    edge_d = 1'b0;
    case (i_edge_mode)
      EDGE_RISE, EDGE_RISE_ALT: edge_d = rise;
      EDGE_FALL:                edge_d = fall;
      EDGE_BOTH:                edge_d = rise | fall;
      default:                  edge_d = rise;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      lvl_prev_q <= 1'b0;
      edge_q     <= 1'b0;
      stab_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      lvl_prev_q <= lvl_prev_d;
      edge_q     <= edge_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  assign o_edge = edge_q;

endmodule

// File: rtl/encoder_tracker.sv
// Code-disc tracker: tooth period measurement, missing-tooth zero detection,
// tooth index tracking with lock/loss supervision and per-tooth RAM writes.
module encoder_tracker
  import encoder_pkg::*;
#(
  parameter int TOOTH_NUM     = 100,
  parameter int ADDR_W        = 7,
  parameter int PERIOD_W      = 24,
  parameter int FILTER_CYC    = 8,
  parameter int ZERO_RATIO_Q2 = 6,
  parameter int TIMEOUT_CYC   = 2_000_000,
  parameter int LOCK_REVS     = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_code_sigin,
  input  logic [1:0]          i_edge_mode,
  input  logic                i_cal_mode,
  input  logic                i_motor_state,
  output logic [ADDR_W-1:0]   o_code_wraddr,
  output logic [31:0]         o_code_wrdata,
  output logic                o_code_wren,
  output logic                o_zero_sign,
  output logic                o_tooth_edge,
  output logic [ADDR_W-1:0]   o_tooth_idx,
  output logic [PERIOD_W-1:0] o_tooth_phase,
  output logic                o_locked,
  output logic [7:0]          o_err_cnt
);

  localparam int CMP_W = PERIOD_W + 3;

  if (!addr_w_ok(TOOTH_NUM, ADDR_W)) begin : g_bad_addr_w
    $error("encoder_tracker: ADDR_W cannot index TOOTH_NUM teeth");
  end

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_prev_q, period_prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
  logic [31:0]         wrdata_q, wrdata_d;
  logic [7:0]          revs_q, revs_d;
  logic [7:0]          err_q, err_d;
  logic                zero_q, zero_d;
  logic                wren_q, wren_d;
  logic                qedge, abort, take, gap, last_tooth;
  logic [7:0]          revs_inc;
  logic [CMP_W-1:0]    cur_scaled, prev_scaled;

  encoder_input_filter #(
    .FILTER_CYC(FILTER_CYC)
  ) u_filter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sig      (i_code_sigin),
    .i_edge_mode(i_edge_mode),
    .i_cal_mode (i_cal_mode),
    .o_edge     (qedge)
  );

  always_comb begin
    abort       = !i_motor_state || (cnt_q >= PERIOD_W'(TIMEOUT_CYC));
    take        = qedge && !abort;
    cur_scaled  = CMP_W'(cnt_q) * CMP_W'(Q2_SCALE);
    prev_scaled = CMP_W'(period_prev_q) * CMP_W'(ZERO_RATIO_Q2);
    gap         = prev_valid_q && (cur_scaled > prev_scaled);
    last_tooth  = (idx_q == ADDR_W'(TOOTH_NUM - 1));
    revs_inc    = revs_q + 8'd1;

    // The counter measures the signal itself, so it restarts on every edge
    // even when the tracker is dropping that edge.
    cnt_d         = qedge ? PERIOD_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + PERIOD_W'(1));
    period_prev_d = qedge ? cnt_q : period_prev_q;

    state_d      = state_q;
    idx_d        = idx_q;
    revs_d       = revs_q;
    err_d        = err_q;
    prev_valid_d = prev_valid_q;
    zero_d       = 1'b0;
    wren_d       = 1'b0;
    wraddr_d     = wraddr_q;
    wrdata_d     = wrdata_q;

    if (abort) begin
      state_d      = IDLE;
      idx_d        = '0;
      prev_valid_d = 1'b0;
    end else if (take) begin
      prev_valid_d = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          state_d = SEEK;
          idx_d   = '0;
        end
        SEEK: begin
          idx_d = '0;
          if (gap) begin
            zero_d  = 1'b1;
            revs_d  = 8'd0;
            state_d = TRACK;
          end
        end
        TRACK, LOCKED: begin
          if (gap && last_tooth) begin
            wren_d   = 1'b1;
            wraddr_d = idx_q;
            wrdata_d = 32'(cnt_q);
            idx_d    = '0;
            zero_d   = 1'b1;
            if (state_q == TRACK) begin
              revs_d = revs_inc;
              if (revs_inc >= 8'(LOCK_REVS)) state_d = LOCKED;
            end
          end else if (gap || last_tooth) begin
            // Zero mark out of place: distrust the index and search again.
            err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            idx_d   = '0;
            state_d = SEEK;
          end else begin
            wren_d   = 1'b1;
            wraddr_d = idx_q;
            wrdata_d = 32'(cnt_q);
            idx_d    = idx_q + ADDR_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      period_prev_q <= '0;
      prev_valid_q  <= 1'b0;
      idx_q         <= '0;
      revs_q        <= '0;
      err_q         <= '0;
      zero_q        <= 1'b0;
      wren_q        <= 1'b0;
      wraddr_q      <= '0;
      wrdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_prev_q <= period_prev_d;
      prev_valid_q  <= prev_valid_d;
      idx_q         <= idx_d;
      revs_q        <= revs_d;
      err_q         <= err_d;
      zero_q        <= zero_d;
      wren_q        <= wren_d;
      wraddr_q      <= wraddr_d;
      wrdata_q      <= wrdata_d;
    end
  end

  assign o_code_wraddr = wraddr_q;
  assign o_code_wrdata = wrdata_q;
  assign o_code_wren   = wren_q;
  assign o_zero_sign   = zero_q;
  assign o_tooth_edge  = qedge;
  assign o_tooth_idx   = idx_q;
  assign o_tooth_phase = cnt_q;
  assign o_locked      = (state_q == LOCKED);
  assign o_err_cnt     = err_q;

endmodule
